// File: rtl/alu_issue.sv
// ============================================================================
// Module   : alu_issue
// Purpose  : Issue/writeback controller feeding the shared combinational ALU
//            from a private register file. Optional macro ALU_ISSUE_BYPASS_EN
//            enables issue during WB with writeback forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issue #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [23:0]           instr_i,
  input  logic                  reg_wr_en_i,
  input  logic [3:0]            reg_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] reg_wr_data_i,
  input  logic [3:0]            dbg_addr_i,
  output logic [DATA_WIDTH-1:0] dbg_data_o,
  output logic [3:0]            alu_opcode_o,
  output logic [DATA_WIDTH-1:0] alu_operand_a_o,
  output logic [DATA_WIDTH-1:0] alu_operand_b_o,
  output logic [7:0]            alu_immediate_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_cmp_flag_i,
  output logic                  wb_valid_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_rd_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  cmp_reg_o,
  output logic                  busy_o
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_CMP = 4'h3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   rf_q [REG_COUNT];
  logic [3:0]              alu_opcode_q;
  logic [DATA_WIDTH-1:0]   operand_a_q;
  logic [DATA_WIDTH-1:0]   operand_b_q;
  logic [7:0]              imm_q;
  logic [3:0]              rd_q;
  logic                    wb_valid_q;
  logic                    wb_we_q;
  logic [3:0]              wb_rd_q;
  logic [DATA_WIDTH-1:0]   wb_data_q;
  logic                    is_cmp_q;
  logic                    flag_q;
  logic                    cmp_reg_q;

  logic [3:0]              rs_addr;
  logic [3:0]              rt_addr;
  logic [DATA_WIDTH-1:0]   operand_a_d;
  logic [DATA_WIDTH-1:0]   operand_b_d;
  logic                    instr_fire;
  logic                    is_arith;

  assign rs_addr = instr_i[15:12];
  assign rt_addr = instr_i[11:8];

  always_comb begin
    instr_ready_o = 1'b0;
    case (state_q)
      S_IDLE:  instr_ready_o = !reg_wr_en_i;
`ifdef ALU_ISSUE_BYPASS_EN
      S_WB:    instr_ready_o = !reg_wr_en_i;
`endif
      default: instr_ready_o = 1'b0;
    endcase
  end

  assign instr_fire = instr_valid_i && instr_ready_o;
  assign is_arith   = (alu_opcode_q == OP_ADD) || (alu_opcode_q == OP_SUB) ||
                      (alu_opcode_q == OP_MUL);

  // R0 and indices beyond REG_COUNT always read as zero.
  always_comb begin
    operand_a_d = '0;
    operand_b_d = '0;
    dbg_data_o  = '0;
    if (rs_addr != 4'd0 && {28'd0, rs_addr} < REG_COUNT) operand_a_d = rf_q[rs_addr];
    if (rt_addr != 4'd0 && {28'd0, rt_addr} < REG_COUNT) operand_b_d = rf_q[rt_addr];
    if (dbg_addr_i != 4'd0 && {28'd0, dbg_addr_i} < REG_COUNT) dbg_data_o = rf_q[dbg_addr_i];
`ifdef ALU_ISSUE_BYPASS_EN
    // The retiring value is not yet in the register file during WB.
    if (state_q == S_WB && wb_we_q && rs_addr == wb_rd_q) operand_a_d = wb_data_q;
    if (state_q == S_WB && wb_we_q && rt_addr == wb_rd_q) operand_b_d = wb_data_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
      alu_opcode_q <= '0;
      operand_a_q  <= '0;
      operand_b_q  <= '0;
      imm_q        <= '0;
      rd_q         <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      is_cmp_q     <= 1'b0;
      flag_q       <= 1'b0;
      cmp_reg_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (reg_wr_en_i && reg_wr_addr_i != 4'd0 && {28'd0, reg_wr_addr_i} < REG_COUNT)
            rf_q[reg_wr_addr_i] <= reg_wr_data_i;
          if (instr_fire) begin
            alu_opcode_q <= instr_i[23:20];
            rd_q         <= instr_i[19:16];
            imm_q        <= instr_i[7:0];
            operand_a_q  <= operand_a_d;
            operand_b_q  <= operand_b_d;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          wb_valid_q <= 1'b1;
          wb_rd_q    <= rd_q;
          wb_we_q    <= is_arith && (rd_q != 4'd0);
          wb_data_q  <= is_arith ? alu_result_i : '0;
          is_cmp_q   <= (alu_opcode_q == OP_CMP);
          flag_q     <= alu_cmp_flag_i;
          state_q    <= S_WB;
        end
        S_WB: begin
          wb_valid_q <= 1'b0;
          wb_we_q    <= 1'b0;
          is_cmp_q   <= 1'b0;
          if (wb_we_q && {28'd0, wb_rd_q} < REG_COUNT) rf_q[wb_rd_q] <= wb_data_q;
          if (is_cmp_q) cmp_reg_q <= flag_q;
          if (instr_fire) begin
            alu_opcode_q <= instr_i[23:20];
            rd_q         <= instr_i[19:16];
            imm_q        <= instr_i[7:0];
            operand_a_q  <= operand_a_d;
            operand_b_q  <= operand_b_d;
            state_q      <= S_EXEC;
          end else begin
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_opcode_o    = alu_opcode_q;
  assign alu_operand_a_o = operand_a_q;
  assign alu_operand_b_o = operand_b_q;
  assign alu_immediate_o = imm_q;
  assign wb_valid_o      = wb_valid_q;
  assign wb_we_o         = wb_we_q;
  assign wb_rd_o         = wb_rd_q;
  assign wb_data_o       = wb_data_q;
  assign cmp_reg_o       = cmp_reg_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ============================================================================
// Module   : tb_alu_issue
// Purpose  : Directed self-checking bench for alu_issue with a behavioural ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] instr;
  logic        reg_wr_en;
  logic [3:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic [3:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_imm;
  logic [7:0]  alu_result;
  logic        alu_cmp_flag;
  logic        wb_valid;
  logic        wb_we;
  logic [3:0]  wb_rd;
  logic [7:0]  wb_data;
  logic        cmp_reg;
  logic        busy;
  logic [15:0] mul_prod;

  int checks = 0;
  int errors = 0;

  alu_issue #(.DATA_WIDTH(8), .REG_COUNT(16)) dut (
    .clk_i(clk), .reset_i(reset),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr),
    .reg_wr_en_i(reg_wr_en), .reg_wr_addr_i(reg_wr_addr), .reg_wr_data_i(reg_wr_data),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data),
    .alu_opcode_o(alu_opcode), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
    .alu_immediate_o(alu_imm), .alu_result_i(alu_result), .alu_cmp_flag_i(alu_cmp_flag),
    .wb_valid_o(wb_valid), .wb_we_o(wb_we), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .cmp_reg_o(cmp_reg), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared ALU: ADD/SUB fold in the immediate, CMP flags a<b.
  assign mul_prod = {8'd0, alu_a} * {8'd0, alu_b};
  always_comb begin
    alu_result = alu_a ^ alu_b ^ alu_imm;
    case (alu_opcode)
      4'h0:    alu_result = alu_a + alu_b + alu_imm;
      4'h1:    alu_result = alu_a - alu_b - alu_imm;
      4'h2:    alu_result = mul_prod[7:0];
      default: alu_result = alu_a ^ alu_b ^ alu_imm;
    endcase
    alu_cmp_flag = (alu_a < alu_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] addr, input logic [7:0] data);
    reg_wr_en   = 1'b1;
    reg_wr_addr = addr;
    reg_wr_data = data;
    #1 chk("ready_low_on_load", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    reg_wr_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1 chk(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  // Starts and ends on a falling edge; the instruction retires in between.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] rd,
                           input logic [3:0] rs, input logic [3:0] rt, input logic [7:0] imm,
                           input logic [7:0] exp_a, input logic [7:0] exp_b,
                           input logic exp_we, input logic [7:0] exp_data);
    instr       = {op, rd, rs, rt, imm};
    instr_valid = 1'b1;
    #1 chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_exec_nowb"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_opa"}, {24'd0, alu_a}, {24'd0, exp_a});
    chk({tag, "_opb"}, {24'd0, alu_b}, {24'd0, exp_b});
    @(negedge clk);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_wb_we"}, {31'd0, wb_we}, {31'd0, exp_we});
    chk({tag, "_wb_rd"}, {28'd0, wb_rd}, {28'd0, rd});
    chk({tag, "_wb_data"}, {24'd0, wb_data}, {24'd0, exp_data});
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, busy, wb_valid}, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    reg_wr_en   = 1'b0;
    reg_wr_addr = '0;
    reg_wr_data = '0;
    dbg_addr    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb", {22'd0, wb_valid, wb_we, wb_rd, wb_data}, 32'd0);
    chk("rst_cmp", {31'd0, cmp_reg}, 32'd0);
    chk("rst_alu", {alu_opcode, alu_imm, alu_a, alu_b[3:0]}, 32'd0);
    read_chk("rst_r1", 4'd1, 8'h00);

    load(4'd1, 8'd5);
    load(4'd2, 8'd3);
    read_chk("load_r1", 4'd1, 8'd5);
    read_chk("load_r2", 4'd2, 8'd3);

    run_instr("add", 4'h0, 4'd3, 4'd1, 4'd2, 8'd2, 8'd5, 8'd3, 1'b1, 8'd10);
    read_chk("add_r3", 4'd3, 8'd10);

    run_instr("sub", 4'h1, 4'd4, 4'd2, 4'd1, 8'd0, 8'd3, 8'd5, 1'b1, 8'hFE);
    read_chk("sub_r4", 4'd4, 8'hFE);

    load(4'd5, 8'h20);
    load(4'd6, 8'h10);
    run_instr("mul", 4'h2, 4'd8, 4'd5, 4'd6, 8'd0, 8'h20, 8'h10, 1'b1, 8'h00);

    run_instr("cmp1", 4'h3, 4'd9, 4'd2, 4'd1, 8'd0, 8'd3, 8'd5, 1'b0, 8'h00);
    chk("cmp1_flag", {31'd0, cmp_reg}, 32'd1);
    read_chk("cmp1_r9", 4'd9, 8'h00);
    run_instr("cmp2", 4'h3, 4'd0, 4'd1, 4'd2, 8'd0, 8'd5, 8'd3, 1'b0, 8'h00);
    chk("cmp2_flag", {31'd0, cmp_reg}, 32'd0);
    run_instr("cmp3", 4'h3, 4'd0, 4'd2, 4'd1, 8'd0, 8'd3, 8'd5, 1'b0, 8'h00);
    chk("cmp3_flag", {31'd0, cmp_reg}, 32'd1);
    // NOP whose operands would clear the flag if it were treated as a compare.
    run_instr("nop", 4'hF, 4'd10, 4'd1, 4'd2, 8'd7, 8'd5, 8'd3, 1'b0, 8'h00);
    chk("nop_flag", {31'd0, cmp_reg}, 32'd1);
    read_chk("nop_r10", 4'd10, 8'h00);

    run_instr("add_r0", 4'h0, 4'd0, 4'd1, 4'd2, 8'd0, 8'd5, 8'd3, 1'b0, 8'd8);
    read_chk("add_r0_val", 4'd0, 8'h00);

    // External write to R0 with an instruction offered at the same time.
    instr       = {4'h0, 4'd11, 4'd1, 4'd2, 8'd0};
    instr_valid = 1'b1;
    load(4'd0, 8'h55);
    instr_valid = 1'b0;
    chk("no_issue_during_load", {31'd0, busy}, 32'd0);
    read_chk("ext_r0", 4'd0, 8'h00);

    // Reset during EXEC drops the instruction.
    instr       = {4'h0, 4'd7, 4'd1, 4'd2, 8'd0};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("rexec_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rexec_wb", {22'd0, wb_valid, wb_we, wb_rd, wb_data}, 32'd0);
    chk("rexec_state", {29'd0, busy, instr_ready, cmp_reg}, 32'd2);
    chk("rexec_alu", {alu_opcode, alu_imm, alu_a, alu_b[3:0]}, 32'd0);
    read_chk("rexec_r7", 4'd7, 8'h00);
    read_chk("rexec_r1", 4'd1, 8'h00);
    @(negedge clk);
    chk("rexec_no_wb_later", {31'd0, wb_valid}, 32'd0);

    // Back-to-back dependent ADDs, second offered continuously.
    load(4'd1, 8'd5);
    load(4'd2, 8'd3);
    instr       = {4'h0, 4'd3, 4'd1, 4'd2, 8'd0};
    instr_valid = 1'b1;
    @(negedge clk);
    instr = {4'h0, 4'd4, 4'd3, 4'd3, 8'd0};
    chk("bp_exec_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("bp_first_wb", {24'd0, wb_data}, 32'd8);
`ifdef ALU_ISSUE_BYPASS_EN
    chk("bp_wb_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("bp_second_exec", {31'd0, busy, wb_valid}, 32'd2);
    chk("bp_fwd_a", {24'd0, alu_a}, 32'd8);
    chk("bp_fwd_b", {24'd0, alu_b}, 32'd8);
`else
    chk("bp_wb_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("bp_idle_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("bp_second_exec", {31'd0, busy, wb_valid}, 32'd2);
    chk("bp_rf_a", {24'd0, alu_a}, 32'd8);
    chk("bp_rf_b", {24'd0, alu_b}, 32'd8);
`endif
    @(negedge clk);
    chk("bp_second_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("bp_second_wb_data", {24'd0, wb_data}, 32'd16);
    @(negedge clk);
    read_chk("bp_r4", 4'd4, 8'd16);
    read_chk("bp_r3", 4'd3, 8'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

Issue and writeback controller that drives the shared `alu` block from the instruction side. Accepts 24-bit ALU instructions over a valid/ready handshake, reads operands from a private register file, presents opcode/operands/immediate to the ALU, captures `result`/`cmp_flag`, and retires the result into the register file and a sticky compare flag. Sits between the per-core fetch/decode stage and the combinational ALU.

## Interface
- `REG_COUNT`, 16: number of registers; must be ≤16 (4-bit index fields). Register 0 is hardwired to zero.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction present.
- `instr_ready` out 1: block can accept an instruction this cycle.
- `instr` in 24: `[23:20]` opcode, `[19:16]` rd, `[15:12]` rs, `[11:8]` rt, `[7:0]` imm.
- `reg_wr_en` in 1: external register load, honoured only in IDLE.
- `reg_wr_addr` in 4 / `reg_wr_data` in `DATA_WIDTH`: external load target and value.
- `dbg_addr` in 4 / `dbg_data` out `DATA_WIDTH`: combinational register read.
- `alu_opcode` out 4, `alu_operand_a` / `alu_operand_b` out `DATA_WIDTH`, `alu_immediate` out 8: registered drive to ALU.
- `alu_result` in `DATA_WIDTH`, `alu_cmp_flag` in 1: ALU outputs.
- `wb_valid` out 1: one-cycle retire pulse.
- `wb_we` out 1: retiring instruction writes a register.
- `wb_rd` out 4, `wb_data` out `DATA_WIDTH`: retiring destination and value.
- `cmp_reg` out 1: sticky compare flag.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE → EXEC → WB → IDLE.
- IDLE: `instr_ready = !reg_wr_en`. On handshake (`instr_valid && instr_ready`) latch opcode/rd/imm into ALU drive registers; latch `operand_a = R[rs]`, `operand_b = R[rt]`; go EXEC.
- EXEC: ALU drive registers stable; at end of cycle capture `alu_result` and `alu_cmp_flag`; go WB.
- WB: `wb_valid=1`, `wb_rd=rd`, `wb_data=` captured result. Register write at end of cycle when `wb_we`; go IDLE (or EXEC, see Configuration).
- `wb_we`: 1 for `OP_ADD`, `OP_SUB`, `OP_MUL` with rd≠0; else 0.
- `OP_CMP`: `cmp_reg` ← captured flag at WB; `wb_data=0`, `wb_we=0`.
- Any other opcode: retired as NOP (`wb_valid` pulses, `wb_we=0`, `wb_data=0`, `cmp_reg` unchanged).
- Arithmetic entirely in the ALU: results truncated to `DATA_WIDTH` (wraparound); imm zero-extended.
- R0 reads 0; writes to R0 (external or writeback) dropped.
- `reg_wr_en` outside IDLE ignored; never coincides with a handshake (ready forced low).

## Timing
- Reset: state IDLE; all registers 0; `cmp_reg=0`, `wb_valid=0`, `wb_we=0`, `wb_rd=0`, `wb_data=0`, all `alu_*` drives 0, `busy=0`, `instr_ready=1`.
- Handshake at edge E0 → EXEC cycle after E0 → `wb_valid` high the cycle after E1 → register visible on `dbg_data` after E2.
- Issue interval: 3 cycles without bypass.
- Reset in EXEC or WB: in-flight instruction dropped, no writeback, no `cmp_reg` update.
- `instr_valid` while `instr_ready=0`: held by sender; nothing latched.

## Configuration
- `ALU_ISSUE_BYPASS_EN` defined: `instr_ready` also high in WB (when `reg_wr_en=0`). A handshake in WB goes straight to EXEC. Operand read forwards `wb_data` when `wb_we` and rs/rt equals `wb_rd`. Issue interval becomes 2 cycles.
- Not defined: `instr_ready=0` in WB; no forwarding logic.

## Test plan
Benches run with `DATA_WIDTH=8`.
- Reset; load R1=5, R2=3; issue ADD rd=3 rs=1 rt=2 imm=2 -> `wb_valid` 2 cycles after handshake, `wb_data=10`, `wb_we=1`; `dbg_addr=3` reads 10.
- SUB rd=4 rs=2 rt=1 imm=0 (3−5) -> `wb_data=0xFE`. MUL with R5=0x20, R6=0x10 -> `wb_data=0x00`.
- CMP rs=2 rt=1 -> `cmp_reg=1`, `wb_we=0`. Then CMP rs=1 rt=2 -> `cmp_reg=0`. Then a NOP opcode -> `cmp_reg` unchanged.
- ADD rd=0 -> `wb_we=0`, R0 stays 0. External write to R0 ignored. `reg_wr_en=1` in IDLE -> `instr_ready=0`.
- Assert `reset` during EXEC of ADD rd=7 -> no `wb_valid`; R7=0; all outputs at reset values the next cycle.
- Bypass: ADD R3=R1+R2 (8), then ADD R4=R3+R3 offered continuously.
  - With `ALU_ISSUE_BYPASS_EN`: second accepted in first's WB cycle; `wb_data=16` two cycles later.
  - Without: second accepted in IDLE, one cycle later; same value.
